// File: rtl/attention_pkg.sv
// Shared types and defaults for the attention head scheduler and accelerator.
package attention_pkg;

  localparam int unsigned NumReqDef   = 4;
  localparam int unsigned NumHeadsDef = 8;

  // Completion record fields are sized generously; the top slices to its own widths.
  localparam int unsigned CplIdW   = 8;
  localparam int unsigned CplHeadW = 8;

  typedef enum logic [1:0] {
    StIdle,
    StLaunch,
    StRun,
    StComplete
  } state_e;

  typedef struct packed {
    logic [CplIdW-1:0]   req_id;
    logic [CplHeadW-1:0] head;
    logic                timeout;
  } cpl_rec_t;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: the first requester at or after i_ptr (mod N) wins.
module rr_arbiter #(
  parameter  int unsigned N = 4,
  localparam int unsigned W = $clog2(N)
) (
  input  logic [N-1:0] i_req,
  input  logic [W-1:0] i_ptr,
  input  logic         i_enable,
  output logic [N-1:0] o_grant,
  output logic [W-1:0] o_winner
);

  logic         w_found;
  logic [W-1:0] w_idx;

  always_comb begin
    o_grant  = '0;
    o_winner = '0;
    w_found  = 1'b0;
    w_idx    = '0;
    for (int unsigned i = 0; i < N; i++) begin
      w_idx = W'((32'(i_ptr) + i) % N);
      if (i_enable && !w_found && i_req[w_idx]) begin
        w_found         = 1'b1;
        o_grant[w_idx]  = 1'b1;
        o_winner        = w_idx;
      end
    end
  end

endmodule

// File: rtl/attention_head_scheduler.sv
// Shares one attention accelerator among NUM_REQ requesters: round-robin grant,
// start pulse, watchdog-guarded wait for done, then a held completion record.
module attention_head_scheduler
  import attention_pkg::*;
#(
  parameter  int unsigned NUM_REQ        = NumReqDef,
  parameter  int unsigned NUM_HEADS      = NumHeadsDef,
  parameter  int unsigned TIMEOUT_CYCLES = 1048576,
  localparam int unsigned HEAD_W         = $clog2(NUM_HEADS),
  localparam int unsigned REQ_W          = $clog2(NUM_REQ),
  localparam int unsigned TO_W           = $clog2(TIMEOUT_CYCLES + 1)
) (
  input  logic                      i_clk,
  input  logic                      i_rst_n,
  input  logic                      i_enable,
  input  logic [NUM_REQ-1:0]        i_req_valid,
  input  logic [NUM_REQ*HEAD_W-1:0] i_req_head,
  output logic [NUM_REQ-1:0]        o_req_ready,
  output logic                      o_acc_start,
  output logic [HEAD_W-1:0]         o_acc_head,
  input  logic                      i_acc_done,
  output logic                      o_cpl_valid,
  input  logic                      i_cpl_ready,
  output logic [REQ_W-1:0]          o_cpl_req_id,
  output logic [HEAD_W-1:0]         o_cpl_head,
  output logic                      o_cpl_timeout,
  output logic                      o_busy
);

  state_e             r_state, w_state_d;
  logic [REQ_W-1:0]   r_ptr, r_req_id, w_winner, w_ptr_next;
  logic [HEAD_W-1:0]  r_head;
  logic [TO_W-1:0]    r_wdog;
  cpl_rec_t           r_cpl, w_cpl_d;
  logic               r_acc_start, r_cpl_valid, r_busy;
  logic [NUM_REQ-1:0] w_grant;
  logic               w_arb_en, w_accept, w_wdog_limit;

  // Gating with reset keeps req_ready low while rst_n is held, before any edge.
  assign w_arb_en = i_rst_n && i_enable && (r_state == StIdle);

  rr_arbiter #(
    .N(NUM_REQ)
  ) u_arb (
    .i_req   (i_req_valid),
    .i_ptr   (r_ptr),
    .i_enable(w_arb_en),
    .o_grant (w_grant),
    .o_winner(w_winner)
  );

  assign o_req_ready  = w_grant;
  assign w_accept     = |w_grant;
  assign w_ptr_next   = (w_winner == REQ_W'(NUM_REQ - 1)) ? '0 : w_winner + 1'b1;
  assign w_wdog_limit = (r_wdog == TO_W'(TIMEOUT_CYCLES - 1));

  always_comb begin
    w_state_d = r_state;
    w_cpl_d   = r_cpl;
    unique case (r_state)
      StIdle:   if (w_accept) w_state_d = StLaunch;
      StLaunch: w_state_d = StRun;
      StRun: begin
        // Done wins over a simultaneous watchdog expiry.
        if (i_acc_done || w_wdog_limit) begin
          w_state_d       = StComplete;
          w_cpl_d.req_id  = CplIdW'(r_req_id);
          w_cpl_d.head    = CplHeadW'(r_head);
          w_cpl_d.timeout = !i_acc_done;
        end
      end
      StComplete: if (i_cpl_ready) w_state_d = StIdle;
      default:    w_state_d = StIdle;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_state     <= StIdle;
      r_ptr       <= '0;
      r_req_id    <= '0;
      r_head      <= '0;
      r_wdog      <= '0;
      r_cpl       <= '0;
      r_acc_start <= 1'b0;
      r_cpl_valid <= 1'b0;
      r_busy      <= 1'b0;
    end else begin
      r_state     <= w_state_d;
      r_cpl       <= w_cpl_d;
      r_acc_start <= (w_state_d == StLaunch);
      r_cpl_valid <= (w_state_d == StComplete);
      r_busy      <= (w_state_d != StIdle);
      if (w_accept) begin
        r_ptr    <= w_ptr_next;
        r_req_id <= w_winner;
        r_head   <= i_req_head[w_winner*HEAD_W +: HEAD_W];
      end
      if (r_state == StLaunch) begin
        r_wdog <= '0;
      end else if (r_state == StRun) begin
        r_wdog <= r_wdog + 1'b1;
      end
    end
  end

  assign o_acc_start   = r_acc_start;
  assign o_acc_head    = r_head;
  assign o_cpl_valid   = r_cpl_valid;
  assign o_cpl_req_id  = r_cpl.req_id[REQ_W-1:0];
  assign o_cpl_head    = r_cpl.head[HEAD_W-1:0];
  assign o_cpl_timeout = r_cpl.timeout;
  assign o_busy        = r_busy;

endmodule

// File: doc/attention_head_scheduler.md
# attention_head_scheduler

Shares a single `attention_accelerator` datapath among several requesters. Each requester submits one job per attention head. The scheduler grants jobs round-robin, launches the accelerator with a one-cycle start pulse, and waits for `done`, with a watchdog guarding the wait. It then returns a completion record to the requester that owned the job. It sits between the host/DMA job sources and the accelerator, and only one job is in flight at a time.

## Interface
- `NUM_REQ`, 4: number of requesters (≥2).
- `NUM_HEADS`, 8: heads per layer; must be a power of two.
- `TIMEOUT_CYCLES`, 1048576: maximum RUN cycles before the job is aborted (≥4).
- Derived: `HEAD_W` = $clog2(NUM_HEADS), `REQ_W` = $clog2(NUM_REQ), `TO_W` = $clog2(TIMEOUT_CYCLES+1).

Ports:
- `clk`  in  1  single clock, rising edge.
- `rst_n`  in  1  reset, synchronous, active-low.
- `enable`  in  1  when low, no new grants are issued; an in-flight job still finishes.
- `req_valid`  in  NUM_REQ  per-requester job request.
- `req_head`  in  NUM_REQ*HEAD_W  head index; requester i uses slice [i*HEAD_W +: HEAD_W].
- `req_ready`  out  NUM_REQ  one-hot grant; a job is accepted when valid&ready.
- `acc_start`  out  1  one-cycle start pulse to the accelerator.
- `acc_head`  out  HEAD_W  head index of the running job; stable from start through completion.
- `acc_done`  in  1  accelerator done pulse.
- `cpl_valid`  out  1  completion record available.
- `cpl_ready`  in  1  completion consumer ready.
- `cpl_req_id`  out  REQ_W  requester that owned the job.
- `cpl_head`  out  HEAD_W  head index of the completed job.
- `cpl_timeout`  out  1  1 means the watchdog expired and no done was seen.
- `busy`  out  1  high in every state except IDLE.

## Operation
States:
- IDLE: when enable=1 and any req_valid is high, req_ready goes high for the round-robin winner (combinational). On acceptance, capture the requester id and req_head, then go to LAUNCH. Otherwise stay in IDLE.
- LAUNCH: acc_start=1 for exactly this cycle; clear the watchdog; go to RUN.
- RUN: the watchdog increments every cycle.
  - acc_done=1 → go to COMPLETE with timeout=0.
  - Watchdog reaches TIMEOUT_CYCLES-1 with acc_done=0 → go to COMPLETE with timeout=1.
  - acc_done on the same cycle the limit is reached: done wins, timeout=0.
- COMPLETE: cpl_valid=1 and the record is held stable until cpl_valid&cpl_ready, then return to IDLE.

Round-robin:
- The search starts at pointer `ptr`; the first requester with valid set, scanning ptr, ptr+1, … (mod NUM_REQ), wins.
- On acceptance, `ptr` becomes winner+1 mod NUM_REQ. It is not updated in any other case.

Other rules:
- acc_done is ignored outside RUN, including a done seen in LAUNCH or a stale done in IDLE or COMPLETE.
- req_ready is 0 in every non-IDLE state, when enable=0, and while rst_n=0.
- A requester that drops req_valid before it is granted loses nothing; its position in the rotation is kept.
- acc_head keeps the last value after completion, until the next acceptance.

## Timing
- Reset (rst_n=0 at an edge): state=IDLE, ptr=0, and all outputs 0 (acc_start, acc_head, cpl_*, busy, req_ready).
- Reset mid-job abandons the job immediately. No completion record is issued, and acc_start is not re-asserted.
- Acceptance at cycle T:
  - acc_start is high at T+1.
  - RUN begins at T+2.
  - The earliest acc_done is sampled at T+2, giving cpl_valid at T+3.
  - With cpl_ready=1 the scheduler is back in IDLE at T+4, and a new grant is possible at T+4.
- Timeout, with no done: cpl_valid asserts exactly TIMEOUT_CYCLES+2 cycles after acceptance.
- All outputs except req_ready are registered.

## Structure
- Shared package `attention_pkg` holds:
  - the state enum (IDLE, LAUNCH, RUN, COMPLETE);
  - a completion record typedef {req_id, head, timeout};
  - localparam defaults for NUM_HEADS/NUM_REQ, shared with `attention_accelerator`.
- One sub-module, `rr_arbiter`, parameterized by N:
  - inputs: req vector, pointer, enable.
  - outputs: one-hot grant and encoded winner.
  - combinational.
- The FSM, watchdog, ptr register and completion register live in the top module.

## Test plan
1. Single job: only req_valid[2]=1, req_head=5, acc_done 10 cycles after start → one acc_start pulse with acc_head=5; cpl_req_id=2, cpl_head=5, cpl_timeout=0.
2. Fairness: all four requesters continuously valid, done immediate → grants in order 0,1,2,3,0,1; no requester is granted twice before the others are served.
3. Watchdog: bench with TIMEOUT_CYCLES=16, acc_done never asserted → cpl_timeout=1 with cpl_valid exactly 18 cycles after acceptance. A late acc_done afterwards is ignored.
4. Backpressure: cpl_ready held 0 for 20 cycles → cpl_valid and the record stay stable, req_ready stays 0, and no new acc_start occurs. The scheduler returns to IDLE one cycle after cpl_ready=1.
5. Reset mid-run: rst_n=0 while in RUN → next cycle all outputs are 0 and ptr=0. After release, requester 0 wins over requester 3 when both are valid.
6. Enable/done collision: enable=0 with requests pending → no grant. Also check the same-cycle case: acc_done coincides with the watchdog limit → cpl_timeout=0.
